// File: rtl/display_pkg.sv
// Shared definitions for the LCD text path: sequencer state encoding and the
// ASCII constants used by byte producers upstream of display_text_feeder.
package display_pkg;

  // Write sequencer states of display_text_feeder.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StAck,
    StDone
  } feeder_state_t;

  // ASCII helpers for producers (message walkers, UART bridges).
  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiMask  = 8'h7F;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy output.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset (flushes the FIFO)
//   push_i, wdata_i    write request and data; ignored while full
//   pop_i, rdata_o     read request; rdata_o shows the head entry (show-ahead)
//   level_o            occupancy 0..DEPTH
//   full_o, empty_o    occupancy flags
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/display_text_feeder.sv
// Character buffer and write sequencer in front of the LCD display controller.
// Bytes arrive on a valid/ready port, queue in a FIFO and are handed to the
// controller one at a time over its ascii_data/write/busy handshake.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   in_data_i, in_valid_i     producer byte and valid
//   in_ready_o                FIFO can accept a byte this cycle
//   disp_data_o, disp_write_o controller ascii_data and single-cycle write
//   disp_busy_i               controller busy
//   level_o                   FIFO occupancy
//   overflow_o                sticky: push attempted while not ready
//   timeout_o                 sticky: controller never acknowledged a write
module display_text_feeder
  import display_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [7:0]             disp_data_o,
  output logic                   disp_write_o,
  input  logic                   disp_busy_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  feeder_state_t state_q, state_d;

  logic [7:0]      data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic            ovf_q, ovf_d;
  logic            to_q, to_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       ack_last, ack_expired;

  // rdy_q keeps the port closed for the first cycle after reset.
  assign in_ready_o  = rdy_q && !fifo_full;
  assign fifo_push   = in_valid_i && in_ready_o;
  assign disp_data_o = data_q;
  assign overflow_o  = ovf_q;
  assign timeout_o   = to_q;

  // cnt_q counts completed ACK cycles; expiry is the edge ending the last one.
  assign ack_last = (cnt_q == CntW'(ACK_TIMEOUT - 1));

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .wdata_i (in_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer: state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty && !disp_busy_i) state_d = StIssue;
      StIssue: state_d = StAck;
      StAck: begin
        if (disp_busy_i)   state_d = StDone;
        else if (ack_last) state_d = StIdle;
      end
      StDone:  if (!disp_busy_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer: outputs.
  always_comb begin
    disp_write_o = 1'b0;
    fifo_pop     = 1'b0;
    ack_expired  = 1'b0;
    unique case (state_q)
      StIdle:  fifo_pop = !fifo_empty && !disp_busy_i;
      StIssue: disp_write_o = 1'b1;
      StAck:   ack_expired = !disp_busy_i && ack_last;
      StDone:  ;
      default: ;
    endcase
  end

  // Datapath and sticky flags.
  always_comb begin
    rdy_d  = 1'b1;
    data_d = data_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q || (in_valid_i && !in_ready_o);
    to_d   = to_q || ack_expired;
    // Latch on pop so the byte stays stable through the whole busy window.
    if (fifo_pop) data_d = fifo_rdata;
    if (state_q == StIssue)    cnt_d = '0;
    else if (state_q == StAck) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy_q  <= 1'b0;
      data_q <= 8'h00;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      rdy_q  <= rdy_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      to_q   <= to_d;
    end
  end

endmodule

// File: tb/tb_display_text_feeder.sv
// Self-checking bench for display_text_feeder: a queue-based reference model
// of the byte stream plus a simple LCD controller model driving disp_busy.
module tb_display_text_feeder;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ACK_TIMEOUT = 1000;
  localparam int unsigned LW          = $clog2(DEPTH) + 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [7:0]    in_data   = 8'h00;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [7:0]    disp_data;
  logic          disp_write;
  logic          disp_busy = 1'b0;
  logic [LW-1:0] level;
  logic          overflow;
  logic          timeout;

  always #5 clk = ~clk;

  display_text_feeder #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .disp_data_o  (disp_data),
    .disp_write_o (disp_write),
    .disp_busy_i  (disp_busy),
    .level_o      (level),
    .overflow_o   (overflow),
    .timeout_o    (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: bytes accepted but not yet seen on the display port.
  logic [7:0] q[$];
  bit m_ovf  = 0;
  bit m_to   = 0;
  bit rdy_ok = 0;
  bit m_rdy  = 0;
  int to_due = -1;

  // Controller model.
  bit mute       = 0;
  bit hold_busy  = 0;
  bit resp_rand  = 0;
  int resp_delay = 2;
  int resp_len   = 5;
  int bz_wait    = 0;
  int bz_left    = 0;
  int bz_len     = 0;

  int nwrites = 0;
  int last_wr = -1;
  int prev_wr = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe on the falling edge, update model, then drive busy.
  // Inputs seen here are the ones the DUT sampled on the preceding rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      m_ovf   = 0;
      m_to    = 0;
      rdy_ok  = 0;
      to_due  = -1;
      mute    = 0;
      bz_wait = 0;
      bz_left = 0;
      check_eq("write_in_reset", disp_write, 0);
      check_eq("data_after_reset", disp_data, 0);
    end else begin
      if (disp_write) begin
        nwrites++;
        prev_wr = last_wr;
        last_wr = cyc;
        if (q.size() == 0) check_eq("write_with_empty_fifo", disp_write, 0);
        else               check_eq("disp_data", disp_data, q.pop_front());
        if (mute) begin
          mute   = 0;
          to_due = cyc + ACK_TIMEOUT + 1;
        end else begin
          bz_wait = resp_rand ? $urandom_range(1, 4) : resp_delay;
          bz_len  = resp_rand ? $urandom_range(1, 8) : resp_len;
        end
      end
      if (in_valid) begin
        if (m_rdy) q.push_back(in_data);
        else       m_ovf = 1;
      end
      if (cyc == to_due) m_to = 1;
      rdy_ok = 1;
    end
    check_eq("level", level, q.size());
    check_eq("in_ready", in_ready, rdy_ok && (q.size() != DEPTH));
    check_eq("overflow", overflow, m_ovf);
    check_eq("timeout", timeout, m_to);
    m_rdy = rdy_ok && (q.size() != DEPTH);
    if (bz_wait > 0) begin
      bz_wait--;
      if (bz_wait == 0) bz_left = bz_len;
    end else if (bz_left > 0) begin
      bz_left--;
    end
    disp_busy = hold_busy || (bz_left > 0);
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);
  endtask

  initial begin
    int k;
    int w0;

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Earliest write: two cycles after the push edge.
    k = cyc;
    push(8'h55);
    tick();
    check_eq("write_latency", last_wr - k, 2);
    idle(12);

    // Two bytes, controller busy for 5 cycles after each write.
    w0 = nwrites;
    push(8'h48);
    push(8'h49);
    idle(30);
    check_eq("two_writes", nwrites - w0, 2);
    check_eq("level_drained", level, 0);

    // Busy held: 17 pushes fill the FIFO and overflow once.
    hold_busy = 1;
    disp_busy = 1'b1;
    idle(2);
    w0 = nwrites;
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    check_eq("full_level", level, DEPTH);
    check_eq("full_not_ready", in_ready, 0);
    check_eq("full_overflow", overflow, 1);
    check_eq("held_no_write", nwrites - w0, 0);
    hold_busy = 0;
    disp_busy = 1'b0;
    idle(200);
    check_eq("drain_16", nwrites - w0, 16);

    // Full FIFO, push coincides with a pop: push refused, level drops to 15.
    do_reset();
    hold_busy = 1;
    disp_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    check_eq("fill_no_overflow", overflow, 0);
    hold_busy = 0;
    disp_busy = 1'b0;
    push(8'hEE);
    check_eq("pop_push_level", level, 15);
    check_eq("pop_push_overflow", overflow, 1);
    idle(200);

    // Controller never acknowledges 0x41; 0x42 follows after the timeout.
    do_reset();
    mute = 1;
    w0 = nwrites;
    push(8'h41);
    push(8'h42);
    idle(ACK_TIMEOUT + 40);
    check_eq("timeout_writes", nwrites - w0, 2);
    check_eq("timeout_gap", last_wr - prev_wr, ACK_TIMEOUT + 2);
    check_eq("timeout_flag", timeout, 1);

    // Reset while waiting in DONE with 5 bytes queued.
    do_reset();
    resp_len = 40;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    idle(3);
    check_eq("queued_before_reset", level, 5);
    check_eq("busy_before_reset", disp_busy, 1);
    reset = 1'b1;
    tick();
    check_eq("reset_level", level, 0);
    check_eq("reset_write", disp_write, 0);
    check_eq("reset_flags", {overflow, timeout}, 0);
    reset = 1'b0;
    idle(2);
    resp_len = 5;
    k = cyc;
    push(8'h5A);
    tick();
    check_eq("post_reset_latency", last_wr - k, 2);
    idle(12);

    // Randomized traffic with random controller response times.
    do_reset();
    resp_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      hold_busy = (((i / 250) % 4) == 3);
      in_valid  = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 80 : 30));
      in_data   = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    hold_busy = 0;
    idle(300);
    check_eq("random_drained", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
